uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, message width, equal to the UART payload width n.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_000_000, the per-message watchdog limit in clk cycles.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port req, input, N, per-requester level request, held until its gnt.
REQ-007 SHALL have port req_data, input, N*W, message of requester i in bits [i*W +: W].
REQ-008 SHALL have port gnt, output, N, one-hot single-cycle pulse acknowledging request capture.
REQ-009 SHALL have port done, output, N, one-hot single-cycle pulse when the owner's message has finished.
REQ-010 SHALL have port start_send, output, 1, drives the UART start_send input.
REQ-011 SHALL have port send_msg_content, output, W, drives the UART send_msg_content input.
REQ-012 SHALL have port tx_busy, input, 1, high while the UART transmitter is shifting a frame.
REQ-013 SHALL have port owner, output, clog2(N), index of the current or last granted requester.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port timeout, output, 1, single-cycle pulse on watchdog abort (macro-dependent).

Function
REQ-016 SHALL implement the states IDLE, START, WAIT and DONE, with all outputs registered.
REQ-017 IDLE: with any req bit high, SHALL select the first set bit searching upward from (last+1) mod N, wrapping around, and go to START on the next edge.
REQ-018 On the IDLE->START edge, SHALL latch req_data of the winner into send_msg_content, set owner, and pulse gnt[owner] for exactly 1 cycle.
REQ-019 START: SHALL hold start_send=1 until tx_busy is sampled 1, then go to WAIT with start_send=0.
REQ-020 WAIT: SHALL go to DONE when tx_busy is sampled 0.
REQ-021 DONE: SHALL pulse done[owner] for 1 cycle, set last=owner, and return to IDLE; a new grant is possible on the following edge.
REQ-022 Latency SHALL be as follows: req high at edge k gives gnt and start_send high after edge k+1.
REQ-023 send_msg_content SHALL remain stable from grant until DONE exits, regardless of req_data changes.
REQ-024 req changes outside IDLE SHALL be ignored; a requester deasserting before its grant loses its turn without side effects.
REQ-025 With a single requester continuously requesting, it SHALL be served back-to-back; with all requesting, grants SHALL rotate 0,1,2,...,N-1,0.
REQ-026 At most one bit of gnt/done SHALL be high in any cycle, and gnt and done SHALL never be high together.

Reset
REQ-027 With rst_n=0 at a clk edge, the block SHALL enter IDLE and set start_send=0, send_msg_content=0, gnt=0, done=0, owner=0, busy=0, timeout=0, last=N-1, and watchdog counter=0.
REQ-028 Reset asserted mid-message SHALL abort the message with no done pulse, and the first grant after reset SHALL go to the lowest-index requester.

Configuration
REQ-029 Macro UART_TX_ARBITER_TIMEOUT_EN defined: a counter SHALL run in START and WAIT and clear on entry to START; on reaching TIMEOUT_CYC the block SHALL force start_send=0, pulse timeout for 1 cycle, set last=owner, and return to IDLE with no done pulse.
REQ-030 Macro UART_TX_ARBITER_TIMEOUT_EN undefined: no counter SHALL exist, timeout SHALL be tied to 0, and START/WAIT SHALL wait indefinitely.

Verification
REQ-031 Reset check: hold rst_n=0 for 3 cycles with req=4'b1111 -> all outputs 0, owner=0; after release, the first gnt is 4'b0001.
REQ-032 Single message: req[2]=1 with data 8'hA5, and a UART model that raises tx_busy 2 cycles after start_send for 10 cycles -> gnt=4'b0100 at k+1, send_msg_content=8'hA5, then done=4'b0100 exactly once.
REQ-033 Round-robin: req=4'b1111 held -> gnt order 0,1,2,3,0, with every data value matching its requester.
REQ-034 Wrap: last=3 and req=4'b1001 -> grant goes to 0; next grant goes to 3.
REQ-035 Data stability: change req_data[owner] during WAIT -> send_msg_content unchanged until DONE.
REQ-036 Timeout (macro on, TIMEOUT_CYC=16): tx_busy stuck at 0 -> start_send drops after 16 cycles, timeout pulses once, no done pulse, and the next requester is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin arbiter feeding one UART transmitter.      |
// | Watchdog abort enabled by UART_TX_ARBITER_TIMEOUT_EN.  Rev 1.0           |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int N           = 4,
   parameter int W           = 8,
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       req_data,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         done,
   output logic                 start_send,
   output logic [W-1:0]         send_msg_content,
   input  logic                 tx_busy,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 timeout
);

   localparam int OW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   logic [OW-1:0] r_last;
   logic          w_found;
   logic [OW-1:0] w_winner;
   logic [OW-1:0] w_sel;
   logic          w_expire;

   // Rotating priority: search upward from the requester after the last owner.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sel    = '0;
      for (int i = 1; i <= N; i++) begin
         w_sel = OW'((int'(r_last) + i) % N);
         if (!w_found && req[w_sel]) begin
            w_found  = 1'b1;
            w_winner = w_sel;
         end
      end
   end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] r_wdog;

   assign w_expire = (r_state == S_START || r_state == S_WAIT) &&
                     (r_wdog == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wdog  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= w_expire;
         if (r_state == S_START || r_state == S_WAIT) begin
            r_wdog <= w_expire ? '0 : r_wdog + 1'b1;
         end else begin
            r_wdog <= '0;
         end
      end
   end
`else
   assign w_expire = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_last           <= OW'(N - 1);
         start_send       <= 1'b0;
         send_msg_content <= '0;
         gnt              <= '0;
         done             <= '0;
         owner            <= '0;
         busy             <= 1'b0;
      end else begin
         gnt  <= '0;
         done <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state          <= S_START;
                  owner            <= w_winner;
                  send_msg_content <= req_data[int'(w_winner)*W +: W];
                  gnt              <= N'(1) << w_winner;
                  start_send       <= 1'b1;
                  busy             <= 1'b1;
               end
            end
            S_START: begin
               if (w_expire) begin
                  r_state    <= S_IDLE;
                  start_send <= 1'b0;
                  r_last     <= owner;
                  busy       <= 1'b0;
               end else if (tx_busy) begin
                  r_state    <= S_WAIT;
                  start_send <= 1'b0;
               end
            end
            S_WAIT: begin
               if (w_expire) begin
                  r_state <= S_IDLE;
                  r_last  <= owner;
                  busy    <= 1'b0;
               end else if (!tx_busy) begin
                  r_state <= S_DONE;
                  done    <= N'(1) << owner;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_last  <= owner;
               busy    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
